// File: rtl/background_vram_responder.sv
// rtl/background_vram_responder.sv - background fetch VRAM read responder with buffered CPU writes
// Fetch reads own the VRAM port; CPU writes wait in a 4-entry FIFO and drain in idle cycles.
module background_vram_responder #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [1:0]        reqTag,
  output logic              rspValid,
  output logic [7:0]        rspData,
  output logic [1:0]        rspTag,
  input  logic              cpuWrValid,
  input  logic [ADDR_W-1:0] cpuWrAddr,
  input  logic [7:0]        cpuWrData,
  output logic              cpuWrReady,
  output logic [2:0]        fifoCount,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [7:0]        memWdata,
  input  logic [7:0]        memRdata
);

  logic [ADDR_W-1:0] fifoAddr [4];
  logic [7:0]        fifoData [4];
  logic [1:0]        wrPtr;
  logic [1:0]        rdPtr;
  logic              push;
  logic              pop;

  // Readiness comes from the registered count only, so a same-cycle drain never frees a slot.
  assign cpuWrReady = (fifoCount != 3'd4);
  assign push       = cpuWrValid && cpuWrReady;
  assign pop        = !reqValid && (fifoCount != 3'd0);

  assign memWe    = pop;
  assign memAddr  = reqValid ? reqAddr : fifoAddr[rdPtr];
  assign memWdata = fifoData[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifoAddr[i] <= '0;
        fifoData[i] <= '0;
      end
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        fifoAddr[wrPtr] <= cpuWrAddr;
        fifoData[wrPtr] <= cpuWrData;
        wrPtr           <= wrPtr + 2'd1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 3'd1;
        2'b01:   fifoCount <= fifoCount - 3'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Walk oldest to newest so the newest matching pending write is the one forwarded.
  logic       fwdHit;
  logic [7:0] fwdData;

  always_comb begin
    fwdHit  = 1'b0;
    fwdData = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < fifoCount) && (fifoAddr[rdPtr + 2'(i)] == reqAddr)) begin
        fwdHit  = 1'b1;
        fwdData = fifoData[rdPtr + 2'(i)];
      end
    end
  end

  logic       s1Valid;
  logic [1:0] s1Tag;
  logic       s1Hit;
  logic [7:0] s1Fwd;
  logic [7:0] stageData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Tag   <= '0;
      s1Hit   <= 1'b0;
      s1Fwd   <= '0;
    end else begin
      s1Valid <= reqValid;
      if (reqValid) begin
        s1Tag <= reqTag;
        s1Hit <= fwdHit;
        s1Fwd <= fwdData;
      end
    end
  end

  assign stageData = s1Hit ? s1Fwd : memRdata;

  generate
    if (LATENCY == 1) begin : g_direct
      logic [7:0] heldData;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          heldData <= '0;
        end else if (s1Valid) begin
          heldData <= stageData;
        end
      end

      assign rspValid = s1Valid;
      assign rspTag   = s1Tag;
      assign rspData  = s1Valid ? stageData : heldData;
    end else begin : g_pipe
      logic       pipeValid [LATENCY-1];
      logic [7:0] pipeData  [LATENCY-1];
      logic [1:0] pipeTag   [LATENCY-1];

      // Data/tag only advance alongside a valid beat so the outputs hold between responses.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            pipeValid[k] <= 1'b0;
            pipeData[k]  <= '0;
            pipeTag[k]   <= '0;
          end
        end else begin
          pipeValid[0] <= s1Valid;
          if (s1Valid) begin
            pipeData[0] <= stageData;
            pipeTag[0]  <= s1Tag;
          end
          for (int k = 1; k < LATENCY - 1; k++) begin
            pipeValid[k] <= pipeValid[k-1];
            if (pipeValid[k-1]) begin
              pipeData[k] <= pipeData[k-1];
              pipeTag[k]  <= pipeTag[k-1];
            end
          end
        end
      end

      assign rspValid = pipeValid[LATENCY-2];
      assign rspData  = pipeData[LATENCY-2];
      assign rspTag   = pipeTag[LATENCY-2];
    end
  endgenerate

endmodule

// File: tb/tb_background_vram_responder.sv
// tb/tb_background_vram_responder.sv - scoreboard bench for background_vram_responder
// Two instances (latency 1 and 3) share stimulus; each has its own RAM model and response queue.
module tb_background_vram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic [15:0] reqAddr;
  logic [1:0]  reqTag;
  logic        cpuWrValid;
  logic [15:0] cpuWrAddr;
  logic [7:0]  cpuWrData;

  logic        rspValid1, rspValid3;
  logic [7:0]  rspData1, rspData3;
  logic [1:0]  rspTag1, rspTag3;
  logic        cpuWrReady1, cpuWrReady3;
  logic [2:0]  fifoCount1, fifoCount3;
  logic [15:0] memAddr1, memAddr3;
  logic        memWe1, memWe3;
  logic [7:0]  memWdata1, memWdata3;
  logic [7:0]  memRdata1, memRdata3;

  always #5 clk = ~clk;

  background_vram_responder #(.LATENCY(1), .ADDR_W(16)) dut1 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqAddr(reqAddr), .reqTag(reqTag),
    .rspValid(rspValid1), .rspData(rspData1), .rspTag(rspTag1),
    .cpuWrValid(cpuWrValid), .cpuWrAddr(cpuWrAddr), .cpuWrData(cpuWrData),
    .cpuWrReady(cpuWrReady1), .fifoCount(fifoCount1),
    .memAddr(memAddr1), .memWe(memWe1), .memWdata(memWdata1), .memRdata(memRdata1)
  );

  background_vram_responder #(.LATENCY(3), .ADDR_W(16)) dut3 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqAddr(reqAddr), .reqTag(reqTag),
    .rspValid(rspValid3), .rspData(rspData3), .rspTag(rspTag3),
    .cpuWrValid(cpuWrValid), .cpuWrAddr(cpuWrAddr), .cpuWrData(cpuWrData),
    .cpuWrReady(cpuWrReady3), .fifoCount(fifoCount3),
    .memAddr(memAddr3), .memWe(memWe3), .memWdata(memWdata3), .memRdata(memRdata3)
  );

  logic [7:0] ram1 [65536];
  logic [7:0] ram3 [65536];
  logic [7:0] committed [65536];

  always @(posedge clk) begin
    if (memWe1) ram1[memAddr1] <= memWdata1;
    memRdata1 <= ram1[memAddr1];
    if (memWe3) ram3[memAddr3] <= memWdata3;
    memRdata3 <= ram3[memAddr3];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] tag;
    int         cyc;
  } rsp_t;

  rsp_t        q1 [$];
  rsp_t        q3 [$];
  logic [15:0] mAddr [$];
  logic [7:0]  mData [$];
  logic [7:0]  heldD [2];
  logic [1:0]  heldT [2];

  int passCount  = 0;
  int checkCount = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ram1[a] = d;
    ram3[a] = d;
    committed[a] = d;
  endtask

  task automatic checkRsp(input string nm, input int which, input logic v,
                          input logic [7:0] d, input logic [1:0] t);
    rsp_t e;
    bit   empty;
    empty = (which == 0) ? (q1.size() == 0) : (q3.size() == 0);
    if (v) begin
      if (empty) begin
        check({nm, "_unexpected_valid"}, 32'(v), 32'd0);
      end else begin
        e = (which == 0) ? q1.pop_front() : q3.pop_front();
        check({nm, "_data"}, 32'(d), 32'(e.data));
        check({nm, "_tag"}, 32'(t), 32'(e.tag));
        check({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
        heldD[which] = e.data;
        heldT[which] = e.tag;
      end
    end else begin
      check({nm, "_hold_data"}, 32'(d), 32'(heldD[which]));
      check({nm, "_hold_tag"}, 32'(t), 32'(heldT[which]));
    end
  endtask

  // Evaluated mid-cycle: outputs reflect the previous edge plus this cycle's inputs.
  task automatic evaluate();
    logic       expPop;
    logic [7:0] expData;
    int         cnt;
    checkRsp("lat1", 0, rspValid1, rspData1, rspTag1);
    checkRsp("lat3", 1, rspValid3, rspData3, rspTag3);
    cnt    = mAddr.size();
    expPop = !reqValid && (cnt > 0);
    check("fifoCount1", 32'(fifoCount1), 32'(cnt));
    check("fifoCount3", 32'(fifoCount3), 32'(cnt));
    check("cpuWrReady1", 32'(cpuWrReady1), 32'(cnt != 4));
    check("memWe1", 32'(memWe1), 32'(expPop));
    check("memWe3", 32'(memWe3), 32'(expPop));
    if (reqValid) begin
      check("memAddr_read", 32'(memAddr1), 32'(reqAddr));
      expData = committed[reqAddr];
      for (int i = 0; i < cnt; i++) begin
        if (mAddr[i] == reqAddr) expData = mData[i];
      end
      q1.push_back('{data: expData, tag: reqTag, cyc: cyc + 1});
      q3.push_back('{data: expData, tag: reqTag, cyc: cyc + 3});
    end
    if (expPop) begin
      check("memAddr_drain", 32'(memAddr1), 32'(mAddr[0]));
      check("memWdata_drain", 32'(memWdata1), 32'(mData[0]));
      committed[mAddr[0]] = mData[0];
      void'(mAddr.pop_front());
      void'(mData.pop_front());
    end
    if (cpuWrValid && cnt != 4) begin
      mAddr.push_back(cpuWrAddr);
      mData.push_back(cpuWrData);
    end
  endtask

  task automatic step(input logic rv, input logic [15:0] ra, input logic [1:0] rt,
                      input logic wv, input logic [15:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    reqValid   = rv;
    reqAddr    = ra;
    reqTag     = rt;
    cpuWrValid = wv;
    cpuWrAddr  = wa;
    cpuWrData  = wd;
    @(negedge clk);
    evaluate();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 8'h0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram1[a] = 8'h00;
      ram3[a] = 8'h00;
      committed[a] = 8'h00;
    end
    heldD[0] = 8'h00; heldD[1] = 8'h00;
    heldT[0] = 2'd0;  heldT[1] = 2'd0;
    reset = 1'b1;
    reqValid = 1'b0; reqAddr = '0; reqTag = '0;
    cpuWrValid = 1'b0; cpuWrAddr = '0; cpuWrData = '0;
    preload(16'h0100, 8'h5A);
    preload(16'h0300, 8'h7E);
    preload(16'h0200, 8'h33);
    for (int i = 0; i < 8; i++) preload(16'h0800 + 16'(i), 8'hC0 + 8'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rspValid1", 32'(rspValid1), 32'd0);
    check("reset_rspData3", 32'(rspData3), 32'd0);
    check("reset_cpuWrReady", 32'(cpuWrReady3), 32'd1);
    check("reset_memWe", 32'(memWe1), 32'd0);
    check("reset_memAddr", 32'(memAddr1), 32'd0);
    check("reset_memWdata", 32'(memWdata1), 32'd0);
    reset = 1'b0;
    idle(7);

    // Single read of a preloaded location.
    step(1'b1, 16'h0100, 2'd2, 1'b0, 16'h0, 8'h0);
    idle(4);

    // Fill the FIFO under continuous fetch traffic; fifth write must be refused.
    for (int i = 0; i < 4; i++)
      step(1'b1, 16'h0500 + 16'(i), 2'(i), 1'b1, 16'h0010 + 16'(i), 8'hA0 + 8'(i));
    step(1'b1, 16'h0504, 2'd0, 1'b1, 16'h0014, 8'hA4);
    check("full_cpuWrReady3", 32'(cpuWrReady3), 32'd0);
    idle(6);
    step(1'b1, 16'h0012, 2'd1, 1'b0, 16'h0, 8'h0);
    step(1'b1, 16'h0014, 2'd3, 1'b0, 16'h0, 8'h0);
    idle(4);

    // Newest pending write to the same address is forwarded.
    step(1'b1, 16'h0600, 2'd0, 1'b1, 16'h0200, 8'h11);
    step(1'b1, 16'h0601, 2'd1, 1'b1, 16'h0200, 8'h22);
    step(1'b1, 16'h0200, 2'd2, 1'b0, 16'h0, 8'h0);
    idle(4);

    // Same-cycle write is not forwarded; it is visible after draining.
    step(1'b1, 16'h0300, 2'd1, 1'b1, 16'h0300, 8'h99);
    idle(2);
    step(1'b1, 16'h0300, 2'd3, 1'b0, 16'h0, 8'h0);
    idle(4);

    // Back-to-back requests with cycling tags.
    for (int i = 0; i < 8; i++)
      step(1'b1, 16'h0800 + 16'(i), 2'(i), 1'b0, 16'h0, 8'h0);
    idle(5);

    // Mixed random traffic over a small address window to exercise forwarding.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 2) != 0), 16'h0040 + 16'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    idle(8);

    // Reset with writes pending and reads in flight.
    step(1'b1, 16'h0700, 2'd0, 1'b1, 16'h0020, 8'h51);
    step(1'b1, 16'h0701, 2'd1, 1'b1, 16'h0021, 8'h52);
    step(1'b1, 16'h0702, 2'd2, 1'b1, 16'h0022, 8'h53);
    reset = 1'b1;
    q1.delete(); q3.delete(); mAddr.delete(); mData.delete();
    heldD[0] = 8'h00; heldD[1] = 8'h00;
    heldT[0] = 2'd0;  heldT[1] = 2'd0;
    idle(2);
    reset = 1'b0;
    idle(6);
    check("post_reset_fifoCount", 32'(fifoCount1), 32'd0);
    check("post_reset_cpuWrReady", 32'(cpuWrReady1), 32'd1);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/background_vram_responder.md
# background_vram_responder

Services the background fetch sequencer's per-tile VRAM read strobes (character, palette, tile-low and tile-high fetches) from a single-port synchronous video RAM. Returns each read with a fixed, guaranteed latency so the sequencer's data-in strobes always find valid data. CPU writes to VRAM are buffered in a 4-entry FIFO and drained only in cycles with no fetch request. Pending-write data is forwarded to reads of the same address. Sits between the background fetch pipeline and the VRAM macro.

## Interface
- LATENCY, 1, cycles from reqValid to rspValid; legal 1..4
- ADDR_W, 16, VRAM address width

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- reqValid  in  1  fetch read request this cycle (one per cycle max)
- reqAddr  in  ADDR_W  fetch address
- reqTag  in  2  fetch kind: 0 char, 1 palette, 2 tileLow, 3 tileHigh
- rspValid  out  1  read data valid
- rspData  out  8  read data
- rspTag  out  2  reqTag echoed with the data
- cpuWrValid  in  1  CPU write offered
- cpuWrAddr  in  ADDR_W  CPU write address
- cpuWrData  in  8  CPU write data
- cpuWrReady  out  1  FIFO can accept; write taken when cpuWrValid & cpuWrReady
- fifoCount  out  3  pending writes, 0..4
- memAddr  out  ADDR_W  VRAM address
- memWe  out  1  VRAM write enable
- memWdata  out  8  VRAM write data
- memRdata  in  8  VRAM read data, valid the cycle after memAddr is presented

## Operation
- VRAM port arbitration per cycle, combinational: reqValid=1 -> memAddr=reqAddr, memWe=0 (fetch always wins). reqValid=0 and fifoCount>0 -> memAddr/memWdata = FIFO head, memWe=1, head popped at the edge. Otherwise memWe=0, memAddr=FIFO head slot contents.
- Write FIFO: 4 entries, circular, 2-bit read/write pointers wrapping 3->0, count 0..4. cpuWrReady = (fifoCount != 4), from registered count only; a pop in the same cycle does not free a slot for that cycle's push.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Forwarding: in the request cycle, reqAddr is compared against every valid FIFO entry; the newest matching entry wins. The hit flag and data are registered. One cycle later, data = hit ? forwarded : memRdata.
- A CPU write accepted in the same cycle as a read to the same address is not forwarded. The read returns the prior value.
- A write drained at cycle N is visible to a RAM read issued at N+1 or later.
- Result (data, tag, valid) passes through LATENCY-1 further register stages to rspData/rspTag/rspValid. The pipeline is fully pipelined: back-to-back requests each get a response.
- No back-pressure on the fetch side. Reads are never stalled or dropped.

## Timing
- Request at edge-cycle N -> rspValid=1 with data/tag during cycle N+LATENCY, for exactly one cycle per request.
- rspData/rspTag hold their last value when rspValid=0.
- Write accepted at N -> fifoCount increments at N+1. Earliest drain is N+1, if that cycle has no request.
- Reset values: rspValid=0, rspData=0, rspTag=0, cpuWrReady=1, fifoCount=0, memWe=0, memAddr=0, memWdata=0; FIFO storage and pointers zeroed.
- Reset mid-operation: all pending writes are discarded and in-flight responses are dropped. No rspValid is asserted for requests issued before reset deassertion.
- Write starvation under continuous requests is permitted; the FIFO fills and cpuWrReady stays 0 until a request-free cycle.

## Test plan
- LATENCY=1, RAM[0x0100]=0x5A; reqValid at cycle 10 with addr 0x0100, tag 2 -> cycle 11: rspValid=1, rspData=0x5A, rspTag=2; memWe=0 throughout.
- Four CPU writes (0x10..0x13 <- 0xA0..0xA3) during continuous fetch requests -> fifoCount reaches 4, cpuWrReady=0, fifth write not taken. After requests stop -> four memWe pulses on consecutive cycles in order, fifoCount returns to 0.
- Write 0x0200<-0x11 then 0x0200<-0x22 queued; read 0x0200 while both pending -> rspData=0x22, not the stale RAM value.
- Read and CPU write to 0x0300 in the same cycle, RAM[0x0300]=0x7E -> rspData=0x7E; a later read after drain -> 0x99 (written value).
- LATENCY=3, requests on 8 consecutive cycles with tags 0,1,2,3,0,1,2,3 -> 8 consecutive rspValid cycles starting 3 after the first request, tags and data in order.
- Assert reset with 3 writes pending and 2 reads in flight -> rspValid stays 0, fifoCount=0, cpuWrReady=1, and no memWe pulses after release.
